// File: rtl/z_meas_pkg.sv
// Shared constants, state encoding and frame helpers for the impedance
// measurement sequencer.
package z_meas_pkg;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned FRAME_W = 32;
   localparam int unsigned CNT_W   = 20;
   localparam int unsigned ELC_W   = 4;
   localparam int unsigned SEL_W   = 5;

   localparam logic [DATA_W-1:0] start_code = 16'hfedc;
   localparam logic [DATA_W-1:0] stop_code  = 16'h0123;
   localparam logic [DATA_W-1:0] test_code  = 16'hff0a;

   typedef enum logic [2:0] {
      IDLE,
      STOP_HDR,
      START_HDR,
      DATA,
      DRAIN,
      ABORT_STOP
   } meas_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
   } frame_t;

   // Sample values that would alias a framing code on the wire
   function automatic logic is_code(input logic [DATA_W-1:0] a);
      return (a == start_code) || (a == stop_code) || (a == test_code);
   endfunction

   function automatic logic [DATA_W-1:0] sub_a(input logic [DATA_W-1:0] a);
      return is_code(a) ? a - DATA_W'(1) : a;
   endfunction

   function automatic frame_t stop_frame(input logic [SEL_W-1:0] sel);
      return '{hi: stop_code, lo: DATA_W'(sel)};
   endfunction

endpackage

// File: rtl/z_meas_seq_if.sv
// Sample input stream and SPI frame output stream of the sequencer.
interface z_meas_seq_if;
   import z_meas_pkg::*;

   logic                sample_valid;
   logic [DATA_W-1:0]   sample_a;
   logic [DATA_W-1:0]   sample_b;
   logic                sample_ready;

   logic                word_valid;
   logic [FRAME_W-1:0]  word_data;
   logic                word_ready;

   modport master (
      input  sample_valid, sample_a, sample_b, word_ready,
      output sample_ready, word_valid, word_data
   );

   modport slave (
      output sample_valid, sample_a, sample_b, word_ready,
      input  sample_ready, word_valid, word_data
   );

endinterface

// File: rtl/z_frame_reg.sv
// Single-entry valid/ready output register holding one 32-bit SPI frame.
module z_frame_reg
   import z_meas_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [FRAME_W-1:0] load_data,
   input  logic               word_ready,
   output logic               word_valid,
   output logic [FRAME_W-1:0] word_data
);

   // A load may coincide with acceptance of the held word (zero bubble)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_valid <= 1'b0;
         word_data  <= '0;
      end else if (load) begin
         word_valid <= 1'b1;
         word_data  <= load_data;
      end else if (word_valid && word_ready) begin
         word_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/z_meas_seq.sv
// Measurement sequencer: stop/start headers, 16 electrodes x N data frames
// from the sample stream, with abort handling that always closes with a stop frame.
module z_meas_seq
   import z_meas_pkg::*;
#(
   parameter int unsigned MAX_ELCTRD = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] stim_cycles,
   input  logic [SEL_W-1:0]  sel_code,
   z_meas_seq_if.master      bus,
   output logic              busy,
   output logic              done,
   output logic              code_sub,
   output logic [ELC_W-1:0]  elctrd_n,
   output logic [DATA_W-1:0] cycle_n
);

   meas_state_t       state_q, state_d;
   logic [DATA_W-1:0] n_q;
   logic [SEL_W-1:0]  sel_q;
   logic [CNT_W-1:0]  frm_cnt_q;
   logic [CNT_W-1:0]  total_frm;
   logic              abort_pend_q, abort_pend_d;
   logic              abort_req;
   logic              acc, room, last_frm;
   logic              ld, take, go, done_d, smp_rdy;
   frame_t            ld_data;

   assign acc       = bus.word_valid & bus.word_ready;
   assign room      = ~bus.word_valid | bus.word_ready;
   assign abort_req = abort | abort_pend_q;
   assign total_frm = CNT_W'(n_q) * CNT_W'(MAX_ELCTRD);
   assign last_frm  = (frm_cnt_q == total_frm - CNT_W'(1));

   assign busy             = (state_q != IDLE);
   assign bus.sample_ready = smp_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state, frame loads and sample acceptance
   always_comb begin
      state_d      = state_q;
      abort_pend_d = abort_pend_q;
      ld           = 1'b0;
      ld_data      = '0;
      smp_rdy      = 1'b0;
      take         = 1'b0;
      go           = 1'b0;
      done_d       = 1'b0;
      case (state_q)
         IDLE: begin
            abort_pend_d = 1'b0;
            if (start && (stim_cycles != '0)) begin
               go      = 1'b1;
               ld      = 1'b1;
               ld_data = stop_frame(sel_code);
               state_d = STOP_HDR;
            end
         end
         ABORT_STOP: begin
            if (acc) state_d = IDLE;
         end
         default: begin
            // Abort outranks every other transition, including the final acceptance
            if (abort_req) begin
               if (room) begin
                  ld           = 1'b1;
                  ld_data      = stop_frame(sel_q);
                  state_d      = ABORT_STOP;
                  abort_pend_d = 1'b0;
               end else begin
                  abort_pend_d = 1'b1;
               end
            end else begin
               case (state_q)
                  STOP_HDR: begin
                     if (acc) begin
                        ld      = 1'b1;
                        ld_data = '{hi: start_code, lo: n_q};
                        state_d = START_HDR;
                     end
                  end
                  START_HDR: begin
                     if (acc) state_d = DATA;
                  end
                  DATA: begin
                     smp_rdy = room;
                     if (bus.sample_valid && room) begin
                        take    = 1'b1;
                        ld      = 1'b1;
                        ld_data = '{hi: sub_a(bus.sample_a), lo: bus.sample_b};
                        if (last_frm) state_d = DRAIN;
                     end
                  end
                  DRAIN: begin
                     if (acc) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   // Measurement parameters, frame/electrode counters and status pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_q          <= '0;
         sel_q        <= '0;
         frm_cnt_q    <= '0;
         abort_pend_q <= 1'b0;
         done         <= 1'b0;
         code_sub     <= 1'b0;
         elctrd_n     <= '0;
         cycle_n      <= '0;
      end else begin
         abort_pend_q <= abort_pend_d;
         done         <= done_d;
         code_sub     <= take & is_code(bus.sample_a);
         if (go) begin
            n_q       <= stim_cycles;
            sel_q     <= sel_code;
            frm_cnt_q <= '0;
            elctrd_n  <= '0;
            cycle_n   <= '0;
         end else if (take) begin
            frm_cnt_q <= frm_cnt_q + CNT_W'(1);
            if (cycle_n == n_q) begin
               cycle_n  <= DATA_W'(1);
               elctrd_n <= elctrd_n + ELC_W'(1);
            end else begin
               cycle_n  <= cycle_n + DATA_W'(1);
            end
         end
      end
   end

   z_frame_reg u_frame_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (ld),
      .load_data  (ld_data),
      .word_ready (bus.word_ready),
      .word_valid (bus.word_valid),
      .word_data  (bus.word_data)
   );

endmodule
